// File: rtl/cone_eval_sched.sv
// cone_eval_sched: round-robin scheduler sharing one multicycle combinational cone among requesters
// Ports:
//   CK, rst_n               clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake; req_ready is one-hot or zero, only in IDLE
//   req_vec                 packed request vectors, requester i at [i*VEC_W +: VEC_W]
//   cone_in/cone_out        registered drive to the shared cone and its 1-bit result
//   resp_valid/resp_ready   result handshake, tagged with resp_id, value resp_bit
//   busy                    high whenever a request is in flight
// Optional macro CONE_SCHED_STATS_EN adds stat_clr, stat_evals and stat_ones saturating counters.
module cone_eval_sched #(
  parameter int NREQ = 4,
  parameter int VEC_W = 35,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W = 16,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  CK,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*VEC_W-1:0] req_vec,
  output logic [VEC_W-1:0]      cone_in,
  input  logic                  cone_out,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic                  resp_bit,
`ifdef CONE_SCHED_STATS_EN
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      stat_evals,
  output logic [CNT_W-1:0]      stat_ones,
`endif
  output logic                  busy
);
  localparam int CW = 4;
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("cone_eval_sched: SETTLE_CYC must be 1..15");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("cone_eval_sched: NREQ must be 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("cone_eval_sched: CNT_W must be positive");
  end
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, gnt, gnt_hi, gnt_lo;
  logic hit_hi, hit_lo;
  logic [CW-1:0] cnt;
  logic [VEC_W-1:0] vec_arr [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_vec
    assign vec_arr[g] = req_vec[g*VEC_W +: VEC_W];
  end
  // Round-robin search split in two: the lowest valid index at or above rr_ptr wins,
  // otherwise the search has wrapped and the lowest valid index overall wins.
  always_comb begin
    gnt_hi = '0;
    gnt_lo = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_lo = IDW'(i);
        hit_lo = 1'b1;
        if (IDW'(i) >= rr_ptr) begin
          gnt_hi = IDW'(i);
          hit_hi = 1'b1;
        end
      end
    end
  end
  assign gnt = hit_hi ? gnt_hi : gnt_lo;
  assign req_ready = (state == IDLE && hit_lo) ? NREQ'(1) << gnt : '0;
  assign busy = state != IDLE;
  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cone_in <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_bit <= 1'b0;
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (hit_lo) begin
            cone_in <= vec_arr[gnt];
            resp_id <= gnt;
            cnt <= CW'(SETTLE_CYC - 1);
            state <= SETTLE;
          end
        SETTLE:
          if (cnt == '0) begin
            resp_bit <= cone_out;
            resp_valid <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        RESP:
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr <= (resp_id == IDW'(NREQ-1)) ? '0 : resp_id + 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CONE_SCHED_STATS_EN
  logic hs;
  assign hs = state == RESP && resp_ready;
  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      stat_evals <= '0;
      stat_ones <= '0;
    end else if (stat_clr) begin
      stat_evals <= '0;
      stat_ones <= '0;
    end else if (hs) begin
      stat_evals <= &stat_evals ? stat_evals : stat_evals + 1'b1;
      stat_ones <= (resp_bit && !(&stat_ones)) ? stat_ones + 1'b1 : stat_ones;
    end
  end
`endif
endmodule

// File: tb/tb_cone_eval_sched.sv
// tb_cone_eval_sched: randomized transaction-level check of cone_eval_sched against a reference model
module tb_cone_eval_sched;
  localparam int NREQ = 4;
  localparam int VEC_W = 35;
  localparam int SETTLE_CYC = 2;
  localparam int CNT_W = 4;
  logic CK = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*VEC_W-1:0] req_vec;
  logic [VEC_W-1:0] cone_in;
  logic cone_out, resp_valid, resp_ready, resp_bit, busy;
  logic [1:0] resp_id;
`ifdef CONE_SCHED_STATS_EN
  logic stat_clr;
  logic [CNT_W-1:0] stat_evals, stat_ones;
  int m_evals, m_ones;
`endif
  int errors = 0, checks = 0, cyc = 0, ptr = 0, acc_cyc = 0, prev_acc;
  logic [VEC_W-1:0] vecs [NREQ];
  logic [VEC_W-1:0] last_vec = '0;

  cone_eval_sched #(.NREQ(NREQ), .VEC_W(VEC_W), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
    .CK(CK), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
    .cone_in(cone_in), .cone_out(cone_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_bit(resp_bit),
`ifdef CONE_SCHED_STATS_EN
    .stat_clr(stat_clr), .stat_evals(stat_evals), .stat_ones(stat_ones),
`endif
    .busy(busy));

  function automatic logic cone_fn(input logic [VEC_W-1:0] v);
    logic [VEC_W-1:0] m;
    m = 35'h5_A5A5_3C3C;
    return (^(v & m)) ^ (v[3] & v[20]);
  endfunction
  assign cone_out = cone_fn(cone_in);

  always #5 CK = ~CK;
  always @(posedge CK) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    return VEC_W'({$urandom, $urandom});
  endfunction

  function automatic int pick(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic load_vecs();
    for (int i = 0; i < NREQ; i++) req_vec[i*VEC_W +: VEC_W] = vecs[i];
  endtask

  task automatic new_vecs();
    for (int i = 0; i < NREQ; i++) vecs[i] = rand_vec();
  endtask

  task automatic scramble();
    req_valid = NREQ'($urandom);
    for (int i = 0; i < NREQ; i++) req_vec[i*VEC_W +: VEC_W] = rand_vec();
  endtask

  // One request/response transaction starting at a negedge with the DUT idle.
  task automatic txn(input logic [NREQ-1:0] mask, input int d, input logic clr);
    int g;
    logic [VEC_W-1:0] v;
    g = pick(mask);
    req_valid = mask;
    load_vecs();
    resp_ready = 1'b0;
    #1;
    check("req_ready", req_ready, g < 0 ? 0 : (1 << g));
    check("idle_busy", busy, 0);
    @(negedge CK);
    if (g < 0) begin
      check("hold_cone_in", cone_in, last_vec);
      check("idle_stay", busy, 0);
      return;
    end
    v = vecs[g];
    last_vec = v;
    acc_cyc = cyc;
    for (int j = 0; j < SETTLE_CYC; j++) begin
      if (j > 0) @(negedge CK);
      scramble();
      #1;
      check("settle_busy", busy, 1);
      check("cone_in", cone_in, v);
      check("early_resp", resp_valid, 0);
      check("ready_in_flight", req_ready, 0);
    end
    @(negedge CK);
    scramble();
    #1;
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, g);
    check("resp_bit", resp_bit, cone_fn(v));
    for (int j = 0; j < d; j++) begin
      @(negedge CK);
      scramble();
      #1;
      check("hold_valid", resp_valid, 1);
      check("hold_id", resp_id, g);
      check("hold_bit", resp_bit, cone_fn(v));
      check("hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
`ifdef CONE_SCHED_STATS_EN
    stat_clr = clr;
    if (clr) begin
      m_evals = 0;
      m_ones = 0;
    end else begin
      if (m_evals < 15) m_evals++;
      if (cone_fn(v) && m_ones < 15) m_ones++;
    end
`endif
    @(negedge CK);
    check("resp_done", resp_valid, 0);
    check("back_idle", busy, 0);
`ifdef CONE_SCHED_STATS_EN
    stat_clr = 1'b0;
    check("stat_evals", stat_evals, m_evals);
    check("stat_ones", stat_ones, m_ones);
`else
    if (clr) check("clr_unused_idle", busy, 0);
`endif
    ptr = (g + 1) % NREQ;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_vec = '0;
    resp_ready = 1'b0;
`ifdef CONE_SCHED_STATS_EN
    stat_clr = 1'b0;
    m_evals = 0;
    m_ones = 0;
`endif
    #1;
    check("rst_cone_in", cone_in, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_bit", resp_bit, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge CK);
    rst_n = 1'b1;
    new_vecs();
    vecs[0] = 35'h1_2345_6789;
    txn(4'b0001, 0, 1'b0);
    prev_acc = -1;
    for (int n = 0; n < 5; n++) begin
      new_vecs();
      txn(4'b1111, 0, 1'b0);
      if (prev_acc >= 0) check("accept_spacing", acc_cyc - prev_acc, SETTLE_CYC + 2);
      prev_acc = acc_cyc;
    end
    new_vecs();
    txn(4'b0010, 5, 1'b0);
    new_vecs();
    txn(4'b0100, 0, 1'b0);
    new_vecs();
    load_vecs();
    req_valid = 4'b0010;
    resp_ready = 1'b1;
    @(negedge CK);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_id", resp_id, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_cone_in", cone_in, 0);
    check("async_resp_valid", resp_valid, 0);
    check("async_busy", busy, 0);
    req_valid = '0;
    @(negedge CK);
    rst_n = 1'b1;
    ptr = 0;
    last_vec = '0;
`ifdef CONE_SCHED_STATS_EN
    m_evals = 0;
    m_ones = 0;
`endif
    repeat (SETTLE_CYC + 2) begin
      @(negedge CK);
      check("no_resp_after_rst", resp_valid, 0);
    end
    new_vecs();
    txn(4'b1111, 0, 1'b0);
    new_vecs();
    txn(4'b1000, 0, 1'b0);
    new_vecs();
    txn(4'b1001, 1, 1'b0);
    new_vecs();
    txn(4'b1001, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      new_vecs();
      txn(NREQ'($urandom), $urandom_range(0, 3), 1'b0);
    end
    new_vecs();
    txn(4'b0110, 0, 1'b1);
    new_vecs();
    txn(4'b0001, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cone_eval_sched.md
Name: cone_eval_sched

Overview:
- Shares one combinational partial-output cone (e.g. the s38584 n6211 cone, 35 inputs to 1 output) between NREQ requesters.
- Accepts an input vector from one requester at a time, chosen round-robin, and drives it onto the cone's input bus from a register.
- Waits a fixed multicycle settle window, captures the 1-bit cone result, and returns it tagged with the requester id.
- Sits between the pattern-generation/test agents and the cone instance.

Parameters:
- NREQ, 4: number of requesters (2..16).
- VEC_W, 35: cone input vector width.
- SETTLE_CYC, 2: cycles the cone input is held before capture (1..15). A value of 0 is illegal; elaboration fails.
- CNT_W, 16: width of statistics counters (optional feature only).

Ports:
- CK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_vec  in  NREQ*VEC_W  request vectors; requester i occupies bits [i*VEC_W +: VEC_W].
- cone_in  out  VEC_W  registered drive to the shared cone inputs.
- cone_out  in  1  cone result (combinational from cone_in).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  $clog2(NREQ)  requester index of the result.
- resp_bit  out  1  captured cone result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: cone_in=0, resp_valid=0, resp_id=0, resp_bit=0, busy=0, state=IDLE, rr_ptr=0, settle counter=0.
- States:
  - IDLE: wait for any request.
  - SETTLE: cone input held, counting the settle window.
  - RESP: result presented until the consumer accepts it.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the rising edge: cone_in <= req_vec[g], resp_id <= g, cnt <= SETTLE_CYC-1, state -> SETTLE.
  - No request valid: outputs hold, state stays IDLE.
- req_ready is 0 for every requester outside IDLE; at most one request is in flight.
- SETTLE:
  - cnt decrements each cycle.
  - At the edge where cnt==0: resp_bit <= cone_out, resp_valid <= 1, state -> RESP.
  - cone_in never changes in SETTLE.
- RESP:
  - resp_valid=1; resp_id and resp_bit are stable.
  - On resp_valid && resp_ready: resp_valid <= 0, rr_ptr <= (resp_id+1) mod NREQ, state -> IDLE.
  - A new grant is possible on the cycle after the response handshake, not the same cycle.
- cone_in is not cleared after a response; it holds the last vector until the next accept.
- Latency: accept at edge E, resp_valid rises at edge E+SETTLE_CYC. Minimum accept-to-accept throughput is SETTLE_CYC+2 cycles with resp_ready tied high.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0,...
- A requester may drop req_valid before being granted; no obligation is recorded.
- rr_ptr wraps from NREQ-1 to 0. For non-power-of-2 NREQ, resp_id never exceeds NREQ-1.
- Reset mid-operation: the in-flight request is abandoned, no response is issued, and all state returns to reset values immediately (asynchronous).
- resp_ready asserted while resp_valid=0 is ignored.

Optional Feature:
- Macro: CONE_SCHED_STATS_EN.
- When defined, adds outputs:
  - stat_evals (CNT_W): count of completed response handshakes.
  - stat_ones (CNT_W): count of handshakes with resp_bit=1.
  - stat_clr (in, 1): synchronous clear.
- Counters saturate at all-ones; they do not wrap.
- stat_clr has priority over an increment in the same cycle.
- Both counters reset to 0.
- When not defined: the ports and logic are absent, and core behaviour is identical.

Test Plan:
1. Reset, then req_valid=4'b0001, req_vec[0]=35'h1_2345_6789, resp_ready=1 → req_ready[0] pulses 1 cycle; cone_in=35'h1_2345_6789 from the next cycle; resp_valid at accept+2 with resp_id=0 and resp_bit=cone_out sampled then.
2. req_valid=4'b1111 held, resp_ready=1 → grant order 0,1,2,3,0; each accept spaced 4 cycles apart (SETTLE_CYC=2).
3. Single request, resp_ready=0 for 5 cycles after resp_valid → resp_valid, resp_id and resp_bit stable; req_ready stays 0 throughout; IDLE resumes one cycle after resp_ready=1.
4. Drive rst_n low during SETTLE → cone_in=0, resp_valid=0, busy=0 immediately; no response emitted; the next grant starts from requester 0.
5. Last grant to 3, then req_valid=4'b1001 → requester 0 is granted (wrap), then 3.
6. With CONE_SCHED_STATS_EN: 3 responses with resp_bit 1,0,1 → stat_evals=3, stat_ones=2. Preload at saturation (CNT_W=4, 15 evals) plus 1 more → stat_evals stays 15. Assert stat_clr together with a handshake → both counters read 0.
